// File: rtl/load_store_unit_if.sv
// Execute-side handshake, data-memory bus and register-file write port of the LSU.
// The slave modport is the LSU view, the master modport is the surrounding core/bus view.
interface load_store_unit_if;
   // Execute handshake
   logic        Valid;
   logic        Ready;
   logic        IsStore;
   logic [2:0]  Funct3;
   logic [31:0] BaseAddr;
   logic [31:0] Offset;
   logic [31:0] StoreData;
   logic [4:0]  Rd;
   // Data-memory bus
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [3:0]  MemWStrb;
   logic [31:0] MemWData;
   logic        MemAck;
   logic [31:0] MemRData;
   // Register-file write port
   logic        RegWEn;
   logic [4:0]  AddrD;
   logic [31:0] DataD;
   // Fault report
   logic        FaultValid;
   logic [1:0]  FaultCode;
   logic [31:0] FaultAddr;

   modport slave (
      input  Valid, IsStore, Funct3, BaseAddr, Offset, StoreData, Rd, MemAck, MemRData,
      output Ready, MemReq, MemWe, MemAddr, MemWStrb, MemWData,
             RegWEn, AddrD, DataD, FaultValid, FaultCode, FaultAddr
   );

   modport master (
      output Valid, IsStore, Funct3, BaseAddr, Offset, StoreData, Rd, MemAck, MemRData,
      input  Ready, MemReq, MemWe, MemAddr, MemWStrb, MemWData,
             RegWEn, AddrD, DataD, FaultValid, FaultCode, FaultAddr
   );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory stage: one load/store per handshake, req/ack data bus with byte/half
// lane steering, single-cycle register-file writeback, fault reporting.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input logic             Clk,
   input logic             Rst,
   load_store_unit_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WRITEBACK,
      FAULT
   } stateT;

   stateT            state;
   logic [CNT_W-1:0] timeoutCnt;
   logic [31:0]      opAddr;
   logic [2:0]       opFunct3;
   logic [4:0]       opRd;
   logic             opIsStore;

   logic [31:0]      effAddr;
   logic             illegal;
   logic             misaligned;
   logic [3:0]       storeStrb;
   logic [31:0]      storeData;
   logic [7:0]       loadByte;
   logic [15:0]      loadHalf;
   logic [31:0]      loadData;

   // Ready is the only combinational output; reset masks it immediately
   always_comb begin
      bus.Ready = (state == IDLE) && !Rst;
   end

   // Decode the presented operation: effective address, legality, alignment, store lanes
   always_comb begin
      effAddr    = bus.BaseAddr + bus.Offset;
      illegal    = bus.IsStore ? (bus.Funct3 > 3'd2)
                               : (bus.Funct3 == 3'd3 || bus.Funct3 == 3'd6 || bus.Funct3 == 3'd7);
      misaligned = 1'b0;
      storeStrb  = 4'b1111;
      storeData  = bus.StoreData;
      case (bus.Funct3[1:0])
         2'b00: begin
            storeStrb = 4'b0001 << effAddr[1:0];
            storeData = {4{bus.StoreData[7:0]}};
         end
         2'b01: begin
            misaligned = effAddr[0];
            storeStrb  = effAddr[1] ? 4'b1100 : 4'b0011;
            storeData  = {2{bus.StoreData[15:0]}};
         end
         2'b10: begin
            misaligned = |effAddr[1:0];
         end
         default: ;
      endcase
      if (!bus.IsStore) begin
         storeStrb = '0;
      end
   end

   // Extract and extend the addressed lane of the returning read word
   always_comb begin
      case (opAddr[1:0])
         2'b00:   loadByte = bus.MemRData[7:0];
         2'b01:   loadByte = bus.MemRData[15:8];
         2'b10:   loadByte = bus.MemRData[23:16];
         default: loadByte = bus.MemRData[31:24];
      endcase
      loadHalf = opAddr[1] ? bus.MemRData[31:16] : bus.MemRData[15:0];
      case (opFunct3)
         3'd0:    loadData = {{24{loadByte[7]}}, loadByte};
         3'd1:    loadData = {{16{loadHalf[15]}}, loadHalf};
         3'd4:    loadData = {24'd0, loadByte};
         3'd5:    loadData = {16'd0, loadHalf};
         default: loadData = bus.MemRData;
      endcase
   end

   // Operation sequencer with registered bus, writeback and fault outputs
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state          <= IDLE;
         timeoutCnt     <= '0;
         opAddr         <= '0;
         opFunct3       <= '0;
         opRd           <= '0;
         opIsStore      <= 1'b0;
         bus.MemReq     <= 1'b0;
         bus.MemWe      <= 1'b0;
         bus.MemAddr    <= '0;
         bus.MemWStrb   <= '0;
         bus.MemWData   <= '0;
         bus.RegWEn     <= 1'b0;
         bus.AddrD      <= '0;
         bus.DataD      <= '0;
         bus.FaultValid <= 1'b0;
         bus.FaultCode  <= '0;
         bus.FaultAddr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Valid) begin
                  opAddr    <= effAddr;
                  opFunct3  <= bus.Funct3;
                  opRd      <= bus.Rd;
                  opIsStore <= bus.IsStore;
                  if (illegal || misaligned) begin
                     // illegal funct3 outranks misalignment
                     state          <= FAULT;
                     bus.FaultValid <= 1'b1;
                     bus.FaultCode  <= illegal ? 2'b10 : 2'b01;
                     bus.FaultAddr  <= effAddr;
                  end else begin
                     state        <= ACCESS;
                     timeoutCnt   <= '0;
                     bus.MemReq   <= 1'b1;
                     bus.MemWe    <= bus.IsStore;
                     bus.MemAddr  <= {effAddr[31:2], 2'b00};
                     bus.MemWStrb <= storeStrb;
                     bus.MemWData <= storeData;
                  end
               end
            end
            ACCESS: begin
               // an ack on the final counted cycle still completes the access
               if (bus.MemAck) begin
                  bus.MemReq <= 1'b0;
                  bus.MemWe  <= 1'b0;
                  if (opIsStore) begin
                     state <= IDLE;
                  end else begin
                     state      <= WRITEBACK;
                     bus.DataD  <= loadData;
                     bus.AddrD  <= opRd;
                     bus.RegWEn <= (opRd != 5'd0);
                  end
               end else if (timeoutCnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  state          <= FAULT;
                  bus.MemReq     <= 1'b0;
                  bus.MemWe      <= 1'b0;
                  bus.FaultValid <= 1'b1;
                  bus.FaultCode  <= 2'b11;
                  bus.FaultAddr  <= opAddr;
               end else begin
                  timeoutCnt <= timeoutCnt + 1'b1;
               end
            end
            WRITEBACK: begin
               bus.RegWEn <= 1'b0;
               state      <= IDLE;
            end
            FAULT: begin
               bus.FaultValid <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed and randomized operations,
// expected per-cycle outputs derived from the latency and lane rules of the LSU.
module tb_load_store_unit;

   localparam int TO   = 16;
   localparam int EMAX = 8192;

   logic Clk = 1'b0;
   logic Rst = 1'b1;

   load_store_unit_if bus ();

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 Clk = ~Clk;

   int edgeCnt = 0;
   always @(posedge Clk) edgeCnt <= edgeCnt + 1;

   int checks   = 0;
   int failures = 0;

   typedef enum int {E_NONE, E_RESET, E_IDLE, E_ACCESS, E_WB, E_FAULT} kindT;

   typedef struct {
      kindT        kind;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic        wen;
      logic [4:0]  addrD;
      logic [31:0] dataD;
      logic [1:0]  fcode;
      logic [31:0] faddr;
   } expT;

   typedef struct {
      logic        isStore;
      logic [2:0]  f3;
      logic [31:0] base;
      logic [31:0] off;
      logic [31:0] sdata;
      logic [4:0]  rd;
      int          ackAt;
      logic [31:0] rdata;
      int          rstAt;
   } opT;

   expT expQ [EMAX];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", name, edgeCnt, act, req);
      end
   endtask

   function automatic void setExp(input int idx, input expT x);
      if (idx >= 0 && idx < EMAX) expQ[idx] = x;
   endfunction

   function automatic expT blankExp(input kindT k);
      expT x;
      x.kind = k; x.we = 0; x.addr = 0; x.strb = 0; x.wdata = 0; x.wen = 0;
      x.addrD = 0; x.dataD = 0; x.fcode = 0; x.faddr = 0;
      return x;
   endfunction

   // ---------------- behavioural model ----------------
   function automatic int accessBytes(input logic [2:0] f3);
      case (f3 % 4)
         0: return 1;
         1: return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [1:0] mFault(input logic st, input logic [2:0] f3, input logic [31:0] ea);
      bit legal;
      legal = st ? (f3 <= 2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (!legal) return 2'b10;
      if (ea % accessBytes(f3) != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] mStrb(input logic st, input logic [2:0] f3, input logic [31:0] ea);
      int unsigned mask;
      if (!st) return 4'b0000;
      mask = (1 << accessBytes(f3)) - 1;
      return 4'((mask << (ea % 4)) & 15);
   endfunction

   function automatic logic [31:0] mWdata(input logic [2:0] f3, input logic [31:0] sd);
      case (accessBytes(f3))
         1: return (sd % 256) * 32'h0101_0101;
         2: return (sd % 65536) * 32'h0001_0001;
         default: return sd;
      endcase
   endfunction

   function automatic logic [31:0] mLoad(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] rdata);
      logic [31:0] v;
      int unsigned bits;
      v    = rdata >> (8 * (ea % 4));
      bits = 8 * accessBytes(f3);
      if (bits < 32) begin
         v = v & ((32'd1 << bits) - 1);
         if (f3 < 4 && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
      end
      return v;
   endfunction

   function automatic opT mkOp(input logic st, input logic [2:0] f3, input logic [31:0] b,
                               input logic [31:0] o, input logic [31:0] sd, input logic [4:0] rd,
                               input int ack, input logic [31:0] rdat, input int rst);
      opT op;
      op.isStore = st; op.f3 = f3; op.base = b; op.off = o; op.sdata = sd; op.rd = rd;
      op.ackAt = ack; op.rdata = rdat; op.rstAt = rst;
      return op;
   endfunction

   // ---------------- compare process ----------------
   initial begin
      expT x;
      int  e;
      forever begin
         @(posedge Clk);
         #2;
         e = edgeCnt;
         if (e < EMAX) begin
            x = expQ[e];
            case (x.kind)
               E_RESET: begin
                  chk("rst_ready", bus.Ready, 0);
                  chk("rst_memreq", bus.MemReq, 0);
                  chk("rst_memwe", bus.MemWe, 0);
                  chk("rst_memaddr", bus.MemAddr, 0);
                  chk("rst_wstrb", bus.MemWStrb, 0);
                  chk("rst_wdata", bus.MemWData, 0);
                  chk("rst_regwen", bus.RegWEn, 0);
                  chk("rst_addrd", bus.AddrD, 0);
                  chk("rst_datad", bus.DataD, 0);
                  chk("rst_faultvalid", bus.FaultValid, 0);
                  chk("rst_faultcode", bus.FaultCode, 0);
                  chk("rst_faultaddr", bus.FaultAddr, 0);
               end
               E_IDLE: begin
                  chk("idle_ready", bus.Ready, 1);
                  chk("idle_memreq", bus.MemReq, 0);
                  chk("idle_regwen", bus.RegWEn, 0);
                  chk("idle_faultvalid", bus.FaultValid, 0);
               end
               E_ACCESS: begin
                  chk("acc_ready", bus.Ready, 0);
                  chk("acc_memreq", bus.MemReq, 1);
                  chk("acc_memwe", bus.MemWe, x.we);
                  chk("acc_memaddr", bus.MemAddr, x.addr);
                  chk("acc_wstrb", bus.MemWStrb, x.strb);
                  if (x.we) chk("acc_wdata", bus.MemWData, x.wdata);
                  chk("acc_regwen", bus.RegWEn, 0);
                  chk("acc_faultvalid", bus.FaultValid, 0);
               end
               E_WB: begin
                  chk("wb_ready", bus.Ready, 0);
                  chk("wb_memreq", bus.MemReq, 0);
                  chk("wb_regwen", bus.RegWEn, x.wen);
                  chk("wb_addrd", bus.AddrD, x.addrD);
                  chk("wb_datad", bus.DataD, x.dataD);
                  chk("wb_faultvalid", bus.FaultValid, 0);
               end
               E_FAULT: begin
                  chk("flt_ready", bus.Ready, 0);
                  chk("flt_memreq", bus.MemReq, 0);
                  chk("flt_regwen", bus.RegWEn, 0);
                  chk("flt_faultvalid", bus.FaultValid, 1);
                  chk("flt_faultcode", bus.FaultCode, x.fcode);
                  chk("flt_faultaddr", bus.FaultAddr, x.faddr);
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic driveJunkOp();
      bus.IsStore   = 1'($urandom);
      bus.Funct3    = 3'($urandom);
      bus.BaseAddr  = $urandom;
      bus.Offset    = $urandom;
      bus.StoreData = $urandom;
      bus.Rd        = 5'($urandom);
   endtask

   // Called at the falling edge of an idle cycle; returns at the falling edge of the
   // first idle cycle after the operation completes.
   task automatic runOp(input opT op);
      int          acc;
      int          busyN;
      int          accessLen;
      int          a;
      logic [31:0] ea;
      logic [1:0]  code;
      expT         x;
      acc = edgeCnt + 1;
      ea  = op.base + op.off;
      code = mFault(op.isStore, op.f3, ea);
      a = -1;
      accessLen = 0;
      bus.Valid     = 1'b1;
      bus.IsStore   = op.isStore;
      bus.Funct3    = op.f3;
      bus.BaseAddr  = op.base;
      bus.Offset    = op.off;
      bus.StoreData = op.sdata;
      bus.Rd        = op.rd;
      bus.MemAck    = 1'($urandom);
      if (code != 2'b00) begin
         x = blankExp(E_FAULT); x.fcode = code; x.faddr = ea;
         setExp(acc, x);
         busyN = 1;
      end else begin
         x = blankExp(E_ACCESS);
         x.we = op.isStore; x.addr = ea - (ea % 4);
         x.strb = mStrb(op.isStore, op.f3, ea); x.wdata = mWdata(op.f3, op.sdata);
         if (op.rstAt >= 0) begin
            accessLen = op.rstAt + 1;
            for (int k = 0; k < accessLen; k++) setExp(acc + k, x);
            setExp(acc + accessLen, blankExp(E_RESET));
            busyN = accessLen + 1;
         end else if (op.ackAt >= 0 && op.ackAt < TO) begin
            a = op.ackAt;
            accessLen = a + 1;
            for (int k = 0; k < accessLen; k++) setExp(acc + k, x);
            if (op.isStore) begin
               busyN = accessLen;
            end else begin
               x = blankExp(E_WB);
               x.wen = (op.rd != 0); x.addrD = op.rd; x.dataD = mLoad(op.f3, ea, op.rdata);
               setExp(acc + accessLen, x);
               busyN = accessLen + 1;
            end
         end else begin
            accessLen = TO;
            for (int k = 0; k < TO; k++) setExp(acc + k, x);
            x = blankExp(E_FAULT); x.fcode = 2'b11; x.faddr = ea;
            setExp(acc + TO, x);
            busyN = TO + 1;
         end
      end
      setExp(acc + busyN, blankExp(E_IDLE));
      for (int k = 0; k < busyN; k++) begin
         @(negedge Clk);
         if (k < accessLen) begin
            bus.MemAck   = (k == a) || (op.rstAt >= 0 && k == op.rstAt);
            bus.MemRData = (k == a) ? op.rdata : $urandom;
         end else begin
            bus.MemAck   = (op.ackAt == TO && k == TO) ? 1'b1 : 1'($urandom);
            bus.MemRData = $urandom;
         end
         if (op.rstAt >= 0 && k == op.rstAt) Rst = 1'b1;
         if (op.rstAt >= 0 && k == op.rstAt + 1) Rst = 1'b0;
         if (k < busyN - 1) begin
            bus.Valid = ($urandom % 3 == 0);
            driveJunkOp();
         end else begin
            bus.Valid = 1'b0;
         end
      end
      @(negedge Clk);
   endtask

   task automatic idleCycle();
      bus.Valid  = 1'b0;
      bus.MemAck = 1'($urandom);
      setExp(edgeCnt + 1, blankExp(E_IDLE));
      @(negedge Clk);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cycle=%0d actual=running required=finished", edgeCnt);
      $fatal(1, "watchdog expired");
   end

   initial begin
      opT op;
      int r;
      bus.Valid = 1'b0; bus.MemAck = 1'b0; bus.MemRData = '0;
      bus.IsStore = 1'b0; bus.Funct3 = '0; bus.BaseAddr = '0; bus.Offset = '0;
      bus.StoreData = '0; bus.Rd = '0;

      // pin the model to hand-computed values
      chk("pin_lb",  mLoad(3'd0, 32'h203, 32'h80FF0102), 32'hFFFF_FF80);
      chk("pin_lbu", mLoad(3'd4, 32'h203, 32'h80FF0102), 32'h0000_0080);
      chk("pin_lh",  mLoad(3'd1, 32'h202, 32'h80FF0102), 32'hFFFF_80FF);
      chk("pin_lw",  mLoad(3'd2, 32'h104, 32'hDEADBEEF), 32'hDEAD_BEEF);
      chk("pin_sb_strb",  mStrb(1'b1, 3'd0, 32'h301), 4'b0010);
      chk("pin_sb_wdata", mWdata(3'd0, 32'h0000_00AB), 32'hABAB_ABAB);
      chk("pin_sh_strb",  mStrb(1'b1, 3'd1, 32'h302), 4'b1100);
      chk("pin_sh_wdata", mWdata(3'd1, 32'h0000_1234), 32'h1234_1234);
      chk("pin_mis",  mFault(1'b0, 3'd2, 32'h102), 2'b01);
      chk("pin_ill",  mFault(1'b0, 3'd3, 32'h101), 2'b10);
      chk("pin_ills", mFault(1'b1, 3'd4, 32'h100), 2'b10);

      // reset held for a few cycles
      @(negedge Clk);
      repeat (3) begin
         setExp(edgeCnt + 1, blankExp(E_RESET));
         @(negedge Clk);
      end
      Rst = 1'b0;
      setExp(edgeCnt + 1, blankExp(E_IDLE));
      @(negedge Clk);

      // directed operations
      runOp(mkOp(0, 3'd2, 32'h100, 32'h4, 0, 5'd5, 0, 32'hDEADBEEF, -1));
      runOp(mkOp(0, 3'd0, 32'h200, 32'h3, 0, 5'd6, 1, 32'h80FF0102, -1));
      runOp(mkOp(0, 3'd4, 32'h200, 32'h3, 0, 5'd7, 0, 32'h80FF0102, -1));
      runOp(mkOp(0, 3'd1, 32'h200, 32'h2, 0, 5'd8, 2, 32'h80FF0102, -1));
      runOp(mkOp(1, 3'd0, 32'h300, 32'h1, 32'h0000_00AB, 5'd9, 2, 0, -1));
      runOp(mkOp(1, 3'd1, 32'h300, 32'h2, 32'h0000_1234, 5'd10, 0, 0, -1));
      runOp(mkOp(0, 3'd2, 32'h100, 32'h2, 0, 5'd11, 0, 0, -1));
      runOp(mkOp(0, 3'd3, 32'h100, 32'h1, 0, 5'd12, 0, 0, -1));
      runOp(mkOp(0, 3'd2, 32'h400, 32'h0, 0, 5'd13, -1, 0, -1));
      runOp(mkOp(0, 3'd2, 32'h404, 32'h0, 0, 5'd14, TO, 32'h1111_2222, -1));
      runOp(mkOp(0, 3'd2, 32'h408, 32'h0, 0, 5'd15, TO - 1, 32'h3333_4444, -1));
      runOp(mkOp(0, 3'd2, 32'h500, 32'h0, 0, 5'd0, 0, 32'h5555_6666, -1));
      runOp(mkOp(0, 3'd2, 32'h600, 32'h0, 0, 5'd16, -1, 0, 3));
      runOp(mkOp(1, 3'd2, 32'h4, 32'hFFFF_FFFC, 32'hCAFE_F00D, 5'd1, 1, 0, -1));
      idleCycle();

      // randomized operations
      for (int n = 0; n < 200; n++) begin
         op.isStore = 1'($urandom);
         op.f3      = 3'($urandom);
         op.base    = $urandom;
         if ($urandom % 2 == 0) op.base[1:0] = 2'b00;
         op.off     = $urandom & 32'hFFFF_FFFC;
         op.sdata   = $urandom;
         op.rd      = 5'($urandom);
         op.rdata   = $urandom;
         r = $urandom % 20;
         if (r < 14)      op.ackAt = $urandom_range(0, 4);
         else if (r < 16) op.ackAt = TO - 1;
         else if (r < 17) op.ackAt = TO;
         else if (r < 18) op.ackAt = -1;
         else             op.ackAt = $urandom_range(5, 12);
         op.rstAt = ($urandom % 25 == 0) ? $urandom_range(0, 3) : -1;
         runOp(op);
         repeat ($urandom_range(0, 2)) idleCycle();
      end

      idleCycle();
      idleCycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
